// File: rtl/rv32im_csr_exec.sv
// Zicsr executor: one read-modify-write access into the CSR file per instruction.
// The old CSR value goes back to writeback over a valid/ready handshake.
module rv32im_csr_exec #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        funct3_i,
  input  logic [CSR_AW-1:0] csr_addr_i,
  input  logic [XLEN-1:0]   rs1_val_i,
  input  logic [4:0]        rs1_idx_i,
  input  logic [4:0]        rd_idx_i,
  input  logic [1:0]        priviledge_mode_i,
  output logic [CSR_AW-1:0] csr_addr_o,
  output logic              csr_read_en_o,
  input  logic [XLEN-1:0]   csr_rdata_i,
  output logic              csr_write_en_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [4:0]        wb_rd_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic              illegal_o
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t            state;
  logic [1:0]        op_kind;
  logic [XLEN-1:0]   op_val;
  logic [XLEN-1:0]   old_val;
  logic [4:0]        rd_reg;
  logic              do_rd;
  logic              do_wr;

  logic [XLEN-1:0]   req_op;
  logic              req_is_rw;
  logic              req_do_rd;
  logic              req_do_wr;
  logic              req_illegal;
  logic [XLEN-1:0]   rd_old;
  logic [XLEN-1:0]   new_val;

  // Decode of the incoming request; only consumed on the accept edge.
  always_comb begin
    req_op      = funct3_i[2] ? {{(XLEN-5){1'b0}}, rs1_idx_i} : rs1_val_i;
    req_is_rw   = (funct3_i[1:0] == 2'b01);
    req_do_rd   = req_is_rw ? (rd_idx_i != 5'd0) : 1'b1;
    // Set/clear forms write based on the rs1 field, not on the operand value.
    req_do_wr   = req_is_rw ? 1'b1 : (rs1_idx_i != 5'd0);
    req_illegal = (funct3_i[1:0] == 2'b00)
               || (req_do_wr && (csr_addr_i[11:10] == 2'b11))
               || (csr_addr_i[9:8] > priviledge_mode_i);
  end

  always_comb begin
    rd_old = do_rd ? csr_rdata_i : '0;
    case (op_kind)
      2'b01:   new_val = op_val;
      2'b10:   new_val = rd_old | op_val;
      default: new_val = rd_old & ~op_val;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= IDLE;
      req_ready_o    <= 1'b1;
      csr_read_en_o  <= 1'b0;
      csr_write_en_o <= 1'b0;
      wb_valid_o     <= 1'b0;
      illegal_o      <= 1'b0;
      wb_rd_o        <= '0;
      wb_data_o      <= '0;
      csr_wdata_o    <= '0;
      csr_addr_o     <= '0;
      op_kind        <= '0;
      op_val         <= '0;
      old_val        <= '0;
      rd_reg         <= '0;
      do_rd          <= 1'b0;
      do_wr          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            req_ready_o <= 1'b0;
            op_kind     <= funct3_i[1:0];
            op_val      <= req_op;
            rd_reg      <= rd_idx_i;
            do_rd       <= req_do_rd;
            do_wr       <= req_do_wr;
            if (req_illegal) begin
              state      <= RESP;
              wb_valid_o <= 1'b1;
              illegal_o  <= 1'b1;
              wb_rd_o    <= '0;
              wb_data_o  <= '0;
            end else begin
              state         <= READ;
              csr_addr_o    <= csr_addr_i;
              csr_read_en_o <= req_do_rd;
            end
          end
        end
        READ: begin
          csr_read_en_o <= 1'b0;
          old_val       <= rd_old;
          if (do_wr) begin
            state          <= WRITE;
            csr_write_en_o <= 1'b1;
            csr_wdata_o    <= new_val;
          end else begin
            state      <= RESP;
            wb_valid_o <= 1'b1;
            wb_data_o  <= rd_old;
            wb_rd_o    <= rd_reg;
            illegal_o  <= 1'b0;
          end
        end
        WRITE: begin
          state          <= RESP;
          csr_write_en_o <= 1'b0;
          wb_valid_o     <= 1'b1;
          wb_data_o      <= old_val;
          wb_rd_o        <= rd_reg;
          illegal_o      <= 1'b0;
        end
        RESP: begin
          if (wb_ready_i) begin
            state       <= IDLE;
            wb_valid_o  <= 1'b0;
            illegal_o   <= 1'b0;
            req_ready_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32im_csr_exec.sv
// Directed bench for rv32im_csr_exec: cycle-exact strobe checks in the stimulus,
// writeback responses checked by a scoreboard monitor.
module tb_rv32im_csr_exec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  funct3 = '0;
  logic [11:0] csr_addr = '0;
  logic [31:0] rs1_val = '0;
  logic [4:0]  rs1_idx = '0;
  logic [4:0]  rd_idx = '0;
  logic [1:0]  priv = 2'd3;
  logic [11:0] csr_addr_out;
  logic        csr_read_en;
  logic [31:0] csr_rdata = '0;
  logic        csr_write_en;
  logic [31:0] csr_wdata;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ill;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  rv32im_csr_exec #(.XLEN(32), .CSR_AW(12)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .funct3_i(funct3), .csr_addr_i(csr_addr), .rs1_val_i(rs1_val),
    .rs1_idx_i(rs1_idx), .rd_idx_i(rd_idx), .priviledge_mode_i(priv),
    .csr_addr_o(csr_addr_out), .csr_read_en_o(csr_read_en),
    .csr_rdata_i(csr_rdata), .csr_write_en_o(csr_write_en),
    .csr_wdata_o(csr_wdata), .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
    .wb_rd_o(wb_rd), .wb_data_o(wb_data), .illegal_o(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted writeback response is matched against the queue.
  always @(negedge clk) begin
    if (rst_n && wb_valid && wb_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual rd=%0d data=%h expected=none", wb_rd, wb_data);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, mon_e.rd});
        chk("illegal", {31'd0, illegal}, {31'd0, mon_e.ill});
        if (!mon_e.ill) chk("wb_data", wb_data, mon_e.data);
        $display("resp rd=%0d data=%h illegal=%0b", wb_rd, wb_data, illegal);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
  endtask

  // Called #1 after a rising edge with wb_ready high; returns #1 after the
  // edge that consumes the response.
  task automatic run_req(input logic [2:0] f3, input logic [11:0] addr,
                         input logic [31:0] rs1v, input logic [4:0] rs1i,
                         input logic [4:0] rd, input logic [1:0] pm,
                         input logic [31:0] rdata, input logic exp_rd_en,
                         input logic exp_wr, input logic [31:0] exp_wdata,
                         input logic exp_ill, input logic [31:0] exp_old);
    exp_t e;
    wait_ready();
    e.rd = exp_ill ? 5'd0 : rd;
    e.data = exp_old;
    e.ill = exp_ill;
    sb.push_back(e);
    $display("req f3=%b addr=%h rs1=%h zimm=%0d rd=%0d priv=%0d rdata=%h",
             f3, addr, rs1v, rs1i, rd, pm, rdata);
    req_valid = 1'b1; funct3 = f3; csr_addr = addr; rs1_val = rs1v;
    rs1_idx = rs1i; rd_idx = rd; priv = pm; csr_rdata = rdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    if (exp_ill) begin
      chk("ill_valid_t1", {31'd0, wb_valid}, 32'd1);
      chk("ill_rd_en", {31'd0, csr_read_en}, 32'd0);
      chk("ill_wr_en", {31'd0, csr_write_en}, 32'd0);
    end else begin
      chk("rd_en_t1", {31'd0, csr_read_en}, {31'd0, exp_rd_en});
      chk("addr_t1", {20'd0, csr_addr_out}, {20'd0, addr});
      chk("wr_en_t1", {31'd0, csr_write_en}, 32'd0);
      chk("valid_t1", {31'd0, wb_valid}, 32'd0);
      @(posedge clk); @(negedge clk);
      if (exp_wr) begin
        chk("wr_en_t2", {31'd0, csr_write_en}, 32'd1);
        chk("wdata_t2", csr_wdata, exp_wdata);
        chk("rd_en_t2", {31'd0, csr_read_en}, 32'd0);
        chk("valid_t2", {31'd0, wb_valid}, 32'd0);
        @(posedge clk); @(negedge clk);
      end
      chk("valid_resp", {31'd0, wb_valid}, 32'd1);
      chk("wr_en_resp", {31'd0, csr_write_en}, 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_strobes", {30'd0, csr_read_en, csr_write_en}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_addr", {20'd0, csr_addr_out}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    //      f3      addr    rs1v          zimm  rd  pm rdata         rd_en wr wdata         ill old
    run_req(3'b001, 12'h340, 32'hDEADBEEF, 5'd1, 5'd5, 2'd3, 32'h12345678, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h12345678);
    run_req(3'b010, 12'h300, 32'hFFFFFFFF, 5'd0, 5'd3, 2'd3, 32'h00000088, 1'b1, 1'b0, 32'h0,        1'b0, 32'h00000088);
    run_req(3'b111, 12'h340, 32'hFFFFFFFF, 5'd8, 5'd2, 2'd3, 32'h0000000F, 1'b1, 1'b1, 32'h00000007, 1'b0, 32'h0000000F);
    run_req(3'b110, 12'h340, 32'h0,        5'd16, 5'd4, 2'd3, 32'h00000001, 1'b1, 1'b1, 32'h00000011, 1'b0, 32'h00000001);
    run_req(3'b001, 12'hF11, 32'h1,        5'd1, 5'd6, 2'd3, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h0);
    run_req(3'b100, 12'h340, 32'h1,        5'd1, 5'd6, 2'd3, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h0);
    run_req(3'b010, 12'h340, 32'h0,        5'd0, 5'd6, 2'd0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h0);
    run_req(3'b010, 12'hF11, 32'h0,        5'd0, 5'd9, 2'd3, 32'h00000489, 1'b1, 1'b0, 32'h0,        1'b0, 32'h00000489);
    run_req(3'b001, 12'h341, 32'h00001000, 5'd3, 5'd0, 2'd3, 32'hAAAAAAAA, 1'b0, 1'b1, 32'h00001000, 1'b0, 32'h0);
    run_req(3'b011, 12'h340, 32'h0000FF00, 5'd2, 5'd8, 2'd3, 32'h0000FFFF, 1'b1, 1'b1, 32'h000000FF, 1'b0, 32'h0000FFFF);
    run_req(3'b010, 12'h340, 32'h0,        5'd9, 5'd8, 2'd3, 32'h0000000A, 1'b1, 1'b1, 32'h0000000A, 1'b0, 32'h0000000A);
    run_req(3'b101, 12'h100, 32'h0,        5'd31, 5'd0, 2'd1, 32'h00000002, 1'b0, 1'b1, 32'h0000001F, 1'b0, 32'h0);

    // Writeback stall with a second request waiting at the input.
    wb_ready = 1'b0;
    sb.push_back('{rd: 5'd6, data: 32'hCAFE0001, ill: 1'b0});
    $display("req f3=001 addr=341 rs1=00000001 rd=6 rdata=cafe0001 (stalled writeback)");
    req_valid = 1'b1; funct3 = 3'b001; csr_addr = 12'h341; rs1_val = 32'h1;
    rs1_idx = 5'd1; rd_idx = 5'd6; priv = 2'd3; csr_rdata = 32'hCAFE0001;
    @(posedge clk); #1;
    req_valid = 1'b0;
    begin
      int n = 0;
      @(negedge clk);
      while (!wb_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("stall_valid_seen", {31'd0, wb_valid}, 32'd1);
    end
    @(posedge clk); #1;
    sb.push_back('{rd: 5'd7, data: 32'h00000055, ill: 1'b0});
    $display("req f3=010 addr=300 zimm=0 rd=7 rdata=00000055 (held during stall)");
    req_valid = 1'b1; funct3 = 3'b010; csr_addr = 12'h300; rs1_idx = 5'd0;
    rd_idx = 5'd7; csr_rdata = 32'h00000055;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, wb_valid}, 32'd1);
      chk("stall_data", wb_data, 32'hCAFE0001);
      chk("stall_ready", {31'd0, req_ready}, 32'd0);
      chk("stall_rd_en", {31'd0, csr_read_en}, 32'd0);
      @(posedge clk); #1;
    end
    wb_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);
    chk("idle_valid", {31'd0, wb_valid}, 32'd0);
    chk("idle_rd_en", {31'd0, csr_read_en}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_rd_en", {31'd0, csr_read_en}, 32'd1);
    chk("b2b_addr", {20'd0, csr_addr_out}, 32'h300);
    @(posedge clk); @(negedge clk);
    chk("b2b_valid", {31'd0, wb_valid}, 32'd1);
    @(posedge clk); #1;

    // Reset during WRITE: write strobe must drop immediately.
    wait_ready();
    $display("req f3=001 addr=340 rs1=11112222 rd=1 (reset during write)");
    req_valid = 1'b1; funct3 = 3'b001; csr_addr = 12'h340; rs1_val = 32'h11112222;
    rs1_idx = 5'd1; rd_idx = 5'd1; priv = 2'd3; csr_rdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstw_rd_en", {31'd0, csr_read_en}, 32'd1);
    @(posedge clk); @(negedge clk);
    chk("rstw_wr_en_before", {31'd0, csr_write_en}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstw_wr_en_after", {31'd0, csr_write_en}, 32'd0);
    chk("rstw_rd_en_after", {31'd0, csr_read_en}, 32'd0);
    chk("rstw_valid", {31'd0, wb_valid}, 32'd0);
    chk("rstw_ready", {31'd0, req_ready}, 32'd1);
    chk("rstw_wdata", csr_wdata, 32'd0);
    chk("rstw_addr", {20'd0, csr_addr_out}, 32'd0);
    chk("rstw_wb_rd", {27'd0, wb_rd}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_wr_en", {31'd0, csr_write_en}, 32'd0);
    chk("post_rst_valid", {31'd0, wb_valid}, 32'd0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
